// File: rtl/stb_dcache_arbiter_if.sv
// Bundles the signals between the load/store arbiter and its neighbours:
// the LSU/MMU load and fence channel, the store-buffer drain channel and
// the single dcache request port.
//   slave  : the arbiter's view (takes requests, drives dcache and acks)
//   master : the surrounding environment (LSU, store buffer, dcache)
interface stb_dcache_arbiter_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4
);
    // LSU/MMU load and fence channel
    logic                      lsummu2arb_ld_req;
    logic [ADDR_WIDTH-1:0]     lsummu2arb_ld_addr;
    logic [BYTE_SEL_WIDTH-1:0] lsummu2arb_ld_sel_byte;
    logic                      arb2lsummu_ld_ack;
    logic [DATA_WIDTH-1:0]     arb2lsummu_ld_rdata;
    logic                      lsummu2arb_fence_req;
    logic                      arb2lsummu_fence_done;

    // Store buffer drain channel
    logic                      stb2arb_req;
    logic [ADDR_WIDTH-1:0]     stb2arb_addr;
    logic [DATA_WIDTH-1:0]     stb2arb_wdata;
    logic [BYTE_SEL_WIDTH-1:0] stb2arb_sel_byte;
    logic                      stb2arb_w_en;
    logic                      stb2arb_empty;
    logic                      arb2stb_ack;

    // Dcache request port
    logic [ADDR_WIDTH-1:0]     arb2dcache_addr;
    logic [DATA_WIDTH-1:0]     arb2dcache_wdata;
    logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte;
    logic                      arb2dcache_w_en;
    logic                      arb2dcache_req;
    logic                      dcache2arb_ack;
    logic [DATA_WIDTH-1:0]     dcache2arb_rdata;

    modport slave (
        input  lsummu2arb_ld_req, lsummu2arb_ld_addr, lsummu2arb_ld_sel_byte,
        input  lsummu2arb_fence_req,
        output arb2lsummu_ld_ack, arb2lsummu_ld_rdata, arb2lsummu_fence_done,
        input  stb2arb_req, stb2arb_addr, stb2arb_wdata, stb2arb_sel_byte,
        input  stb2arb_w_en, stb2arb_empty,
        output arb2stb_ack,
        output arb2dcache_addr, arb2dcache_wdata, arb2dcache_sel_byte,
        output arb2dcache_w_en, arb2dcache_req,
        input  dcache2arb_ack, dcache2arb_rdata
    );

    modport master (
        output lsummu2arb_ld_req, lsummu2arb_ld_addr, lsummu2arb_ld_sel_byte,
        output lsummu2arb_fence_req,
        input  arb2lsummu_ld_ack, arb2lsummu_ld_rdata, arb2lsummu_fence_done,
        output stb2arb_req, stb2arb_addr, stb2arb_wdata, stb2arb_sel_byte,
        output stb2arb_w_en, stb2arb_empty,
        input  arb2stb_ack,
        input  arb2dcache_addr, arb2dcache_wdata, arb2dcache_sel_byte,
        input  arb2dcache_w_en, arb2dcache_req,
        output dcache2arb_ack, dcache2arb_rdata
    );
endinterface

// File: rtl/stb_dcache_arbiter.sv
// Arbitrates the single dcache request port between LSU loads and the
// store-buffer drain. Loads have priority, a starvation counter forces a
// store after STARVE_LIMIT consecutive load wins, and a fence blocks loads
// until the store buffer has fully drained. One dcache transaction is
// outstanding at a time.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - stb_dcache_arbiter_if.slave (load/fence, store drain, dcache)
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no dcache transaction open; requests are evaluated every cycle
// LOAD  | load request presented to dcache, waiting for dcache ack
// STORE | store request presented to dcache, waiting for dcache ack
module stb_dcache_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                clk,
    input  logic                rst,
    stb_dcache_arbiter_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_WIDTH-1:0]      starve_cnt;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [BYTE_SEL_WIDTH-1:0] sel_q;
    logic                      w_en_q;
    logic                      req_q;
    logic                      ld_ack_q;
    logic [DATA_WIDTH-1:0]     ld_rdata_q;
    logic                      stb_ack_q;
    logic                      fence_done_q;
    logic                      fence_sent;

    logic ld_req_eff;
    logic stb_req_eff;
    logic at_limit;
    logic store_wins;
    logic ld_grant;
    logic st_grant;
    logic fence_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A load still counts as pending in its own ack cycle (it is only
    // blocked from being re-granted), so a store cannot slip in there just
    // because the load was masked; loads only lose on starvation or fence.
    always_comb begin
        ld_req_eff  = bus.lsummu2arb_ld_req && !bus.lsummu2arb_fence_req;
        stb_req_eff = bus.stb2arb_req && !stb_ack_q;
        at_limit    = (starve_cnt == CNT_MAX);
        store_wins  = stb_req_eff &&
                      (!ld_req_eff || at_limit || bus.lsummu2arb_fence_req);
        fence_fire  = bus.lsummu2arb_fence_req && !fence_sent &&
                      (state == IDLE) && bus.stb2arb_empty && !bus.stb2arb_req &&
                      !ld_ack_q && !stb_ack_q;
        ld_grant    = 1'b0;
        st_grant    = 1'b0;
        state_nxt   = state;
        case (state)
            IDLE: begin
                if (store_wins) begin
                    st_grant  = 1'b1;
                    state_nxt = STORE;
                end else if (ld_req_eff && !ld_ack_q) begin
                    ld_grant  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD, STORE: begin
                if (bus.dcache2arb_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt   <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
            w_en_q       <= 1'b0;
            req_q        <= 1'b0;
            ld_ack_q     <= 1'b0;
            ld_rdata_q   <= '0;
            stb_ack_q    <= 1'b0;
            fence_done_q <= 1'b0;
            fence_sent   <= 1'b0;
        end else begin
            ld_ack_q     <= 1'b0;
            stb_ack_q    <= 1'b0;
            fence_done_q <= 1'b0;

            if (ld_grant) begin
                addr_q  <= bus.lsummu2arb_ld_addr;
                sel_q   <= bus.lsummu2arb_ld_sel_byte;
                wdata_q <= '0;
                w_en_q  <= 1'b0;
                req_q   <= 1'b1;
            end else if (st_grant) begin
                addr_q  <= bus.stb2arb_addr;
                sel_q   <= bus.stb2arb_sel_byte;
                wdata_q <= bus.stb2arb_wdata;
                w_en_q  <= bus.stb2arb_w_en;
                req_q   <= 1'b1;
            end else if ((state != IDLE) && bus.dcache2arb_ack) begin
                req_q  <= 1'b0;
                w_en_q <= 1'b0;
                if (state == LOAD) begin
                    ld_ack_q   <= 1'b1;
                    ld_rdata_q <= bus.dcache2arb_rdata;
                end else begin
                    stb_ack_q  <= 1'b1;
                end
            end

            // ld_grant can only co-occur with stb2arb_req=1 once the idle
            // clear below has been ruled out, so it counts a starved cycle.
            if (st_grant) begin
                starve_cnt <= '0;
            end else if ((state == IDLE) && !bus.stb2arb_req) begin
                starve_cnt <= '0;
            end else if (ld_grant && !at_limit) begin
                starve_cnt <= starve_cnt + CNT_WIDTH'(1);
            end

            // One done pulse per fence; re-armed once fence_req drops.
            if (!bus.lsummu2arb_fence_req) begin
                fence_sent <= 1'b0;
            end else if (fence_fire) begin
                fence_done_q <= 1'b1;
                fence_sent   <= 1'b1;
            end
        end
    end

    assign bus.arb2dcache_addr       = addr_q;
    assign bus.arb2dcache_wdata      = wdata_q;
    assign bus.arb2dcache_sel_byte   = sel_q;
    assign bus.arb2dcache_w_en       = w_en_q;
    assign bus.arb2dcache_req        = req_q;
    assign bus.arb2lsummu_ld_ack     = ld_ack_q;
    assign bus.arb2lsummu_ld_rdata   = ld_rdata_q;
    assign bus.arb2stb_ack           = stb_ack_q;
    assign bus.arb2lsummu_fence_done = fence_done_q;
endmodule

// File: tb/tb_stb_dcache_arbiter.sv
// Scoreboard bench for stb_dcache_arbiter: stimulus pushes the expected
// dcache transactions / load data; a negedge monitor pops and compares.
module tb_stb_dcache_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    stb_dcache_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW)) bus ();

    stb_dcache_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] sel;
        logic          w_en;
    } txn_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
    } ld_t;

    txn_t          exp_dc[$];
    logic [DW-1:0] exp_rd[$];
    ld_t           ld_q[$];
    txn_t          st_q[$];

    int n_cmp = 0;
    int n_err = 0;
    bit ld_en = 0;
    bit st_en = 0;
    int resp_lat = 3;
    bit stray_ack = 0;
    int exp_fence = 0;
    int fence_seen = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    int last_gap = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : {16'hCAFE, a[15:0]};
    endfunction

    // Requester models: LSU load queue and store buffer.
    initial begin
        bus.lsummu2arb_ld_req      = 1'b0;
        bus.lsummu2arb_ld_addr     = '0;
        bus.lsummu2arb_ld_sel_byte = '0;
        bus.lsummu2arb_fence_req   = 1'b0;
        bus.stb2arb_req            = 1'b0;
        bus.stb2arb_addr           = '0;
        bus.stb2arb_wdata          = '0;
        bus.stb2arb_sel_byte       = '0;
        bus.stb2arb_w_en           = 1'b0;
        bus.stb2arb_empty          = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.arb2lsummu_ld_ack && ld_q.size() > 0) ld_q.delete(0);
            if (bus.arb2stb_ack && st_q.size() > 0) st_q.delete(0);
            bus.lsummu2arb_ld_req = ld_en && (ld_q.size() > 0);
            if (ld_q.size() > 0) begin
                bus.lsummu2arb_ld_addr     = ld_q[0].addr;
                bus.lsummu2arb_ld_sel_byte = ld_q[0].sel;
            end
            bus.stb2arb_req   = st_en && (st_q.size() > 0);
            bus.stb2arb_empty = (st_q.size() == 0);
            if (st_q.size() > 0) begin
                bus.stb2arb_addr     = st_q[0].addr;
                bus.stb2arb_wdata    = st_q[0].wdata;
                bus.stb2arb_sel_byte = st_q[0].sel;
                bus.stb2arb_w_en     = st_q[0].w_en;
            end
        end
    end

    // Dcache responder: acks resp_lat cycles after a request appears.
    initial begin
        bit busy = 0;
        int cnt = 0;
        bus.dcache2arb_ack   = 1'b0;
        bus.dcache2arb_rdata = 32'h1234_5678;
        forever begin
            @(posedge clk);
            #1;
            bus.dcache2arb_ack   = 1'b0;
            bus.dcache2arb_rdata = 32'h1234_5678;
            if (rst) begin
                busy = 0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    bus.dcache2arb_ack   = 1'b1;
                    bus.dcache2arb_rdata = rd_fn(bus.arb2dcache_addr);
                    busy = 0;
                end
            end else if (bus.arb2dcache_req) begin
                busy = 1;
                cnt  = resp_lat;
            end else if (stray_ack) begin
                bus.dcache2arb_ack = 1'b1;
                stray_ack = 0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit p_ack_ld = 0;
        bit p_ack_st = 0;
        bit p_req = 0;
        txn_t t;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                p_ack_ld = 0;
                p_ack_st = 0;
                p_req = 0;
            end else begin
                if (p_ack_ld || bus.arb2lsummu_ld_ack)
                    check("ld_ack_timing", bus.arb2lsummu_ld_ack, p_ack_ld);
                if (p_ack_st || bus.arb2stb_ack)
                    check("stb_ack_timing", bus.arb2stb_ack, p_ack_st);
                if (bus.arb2lsummu_ld_ack) begin
                    if (exp_rd.size() == 0) check("ld_rdata_unexpected", 1, 0);
                    else check("ld_rdata", bus.arb2lsummu_ld_rdata, exp_rd.pop_front());
                end
                if (bus.arb2dcache_req && !p_req) begin
                    last_gap = cyc - last_ack_cyc;
                    if (exp_dc.size() == 0) begin
                        check("dc_req_unexpected", bus.arb2dcache_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        t = exp_dc.pop_front();
                        check("dc_addr", bus.arb2dcache_addr, t.addr);
                        check("dc_wdata", bus.arb2dcache_wdata, t.wdata);
                        check("dc_sel_wen", {bus.arb2dcache_sel_byte, bus.arb2dcache_w_en}, {t.sel, t.w_en});
                        if (t.w_en) check("starve_clr_on_store", dut.starve_cnt, 0);
                    end
                end
                if (bus.arb2lsummu_fence_done) begin
                    check("fence_done_expected", exp_fence > 0, 1);
                    check("fence_done_empty", bus.stb2arb_empty, 1);
                    fence_seen++;
                    if (exp_fence > 0) exp_fence--;
                end
                p_ack_ld = bus.arb2dcache_req && bus.dcache2arb_ack && !bus.arb2dcache_w_en;
                p_ack_st = bus.arb2dcache_req && bus.dcache2arb_ack && bus.arb2dcache_w_en;
                if (bus.arb2dcache_req && bus.dcache2arb_ack) last_ack_cyc = cyc;
                p_req = bus.arb2dcache_req;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((ld_q.size() != 0 || st_q.size() != 0 || exp_dc.size() != 0 ||
                bus.arb2dcache_req) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL wait_idle: timeout got %0d cycles, ld_q=%0d st_q=%0d exp_dc=%0d required idle",
                     n, ld_q.size(), st_q.size(), exp_dc.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 rst = 1'b1;
        #2;
        check("rst_req", bus.arb2dcache_req, 0);
        check("rst_wen", bus.arb2dcache_w_en, 0);
        check("rst_addr_data", {bus.arb2dcache_addr, bus.arb2dcache_wdata}, 0);
        check("rst_acks", {bus.arb2lsummu_ld_ack, bus.arb2stb_ack, bus.arb2lsummu_fence_done,
                           bus.arb2dcache_sel_byte}, 0);
        check("rst_rdata", bus.arb2lsummu_ld_rdata, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ld_en = 1;
        st_en = 1;
        repeat (2) @(negedge clk);

        // Load only, 1-cycle latency to dcache request.
        ld_q.push_back('{32'h40, 4'hF});
        exp_dc.push_back('{32'h40, 32'h0, 4'hF, 1'b0});
        exp_rd.push_back(32'hDEADBEEF);
        @(negedge clk);
        check("ld_lat_before", bus.arb2dcache_req, 0);
        @(negedge clk);
        check("ld_lat_req", {bus.arb2dcache_req, bus.arb2dcache_w_en}, 2'b10);
        wait_idle(100);

        // Store only.
        st_q.push_back('{32'h100, 32'h64, 4'b0100, 1'b1});
        exp_dc.push_back('{32'h100, 32'h64, 4'b0100, 1'b1});
        wait_idle(100);

        // Starvation: L,L,L,L,S,L,L,S.
        ld_en = 0;
        st_en = 0;
        for (int i = 0; i < 6; i++) ld_q.push_back('{32'h200 + 4 * i, 4'hF});
        st_q.push_back('{32'h300, 32'hA1, 4'b0001, 1'b1});
        st_q.push_back('{32'h304, 32'hB2, 4'b0010, 1'b1});
        exp_dc.push_back('{32'h200, 32'h0, 4'hF, 1'b0});
        exp_dc.push_back('{32'h204, 32'h0, 4'hF, 1'b0});
        exp_dc.push_back('{32'h208, 32'h0, 4'hF, 1'b0});
        exp_dc.push_back('{32'h20C, 32'h0, 4'hF, 1'b0});
        exp_dc.push_back('{32'h300, 32'hA1, 4'b0001, 1'b1});
        exp_dc.push_back('{32'h210, 32'h0, 4'hF, 1'b0});
        exp_dc.push_back('{32'h214, 32'h0, 4'hF, 1'b0});
        exp_dc.push_back('{32'h304, 32'hB2, 4'b0010, 1'b1});
        exp_rd.push_back(32'hCAFE0200);
        exp_rd.push_back(32'hCAFE0204);
        exp_rd.push_back(32'hCAFE0208);
        exp_rd.push_back(32'hCAFE020C);
        exp_rd.push_back(32'hCAFE0210);
        exp_rd.push_back(32'hCAFE0214);
        ld_en = 1;
        st_en = 1;
        wait_idle(300);

        // Fence: three stores drain, load held back until fence drops.
        ld_en = 0;
        st_en = 0;
        st_q.push_back('{32'h400, 32'h11, 4'hF, 1'b1});
        st_q.push_back('{32'h404, 32'h22, 4'hF, 1'b1});
        st_q.push_back('{32'h408, 32'h33, 4'hF, 1'b1});
        ld_q.push_back('{32'h500, 4'hF});
        exp_dc.push_back('{32'h400, 32'h11, 4'hF, 1'b1});
        exp_dc.push_back('{32'h404, 32'h22, 4'hF, 1'b1});
        exp_dc.push_back('{32'h408, 32'h33, 4'hF, 1'b1});
        exp_dc.push_back('{32'h500, 32'h0, 4'hF, 1'b0});
        exp_rd.push_back(32'hCAFE0500);
        exp_fence = 1;
        st_en = 1;
        @(negedge clk);
        bus.lsummu2arb_fence_req = 1'b1;
        ld_en = 1;
        n = 0;
        while (fence_seen < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fence_done_seen", fence_seen, 1);
        check("fence_load_blocked", ld_q.size(), 1);
        repeat (3) @(negedge clk);
        bus.lsummu2arb_fence_req = 1'b0;
        wait_idle(100);

        // Fence with an already empty buffer: done one cycle later.
        exp_fence = 1;
        bus.lsummu2arb_fence_req = 1'b1;
        @(negedge clk);
        check("fence_empty_latency", bus.arb2lsummu_fence_done, 1);
        @(negedge clk);
        bus.lsummu2arb_fence_req = 1'b0;
        repeat (2) @(negedge clk);

        // Stray dcache ack while idle is ignored.
        stray_ack = 1;
        repeat (4) @(negedge clk);
        check("stray_ack_req", bus.arb2dcache_req, 0);

        // Simultaneous load and store: load first, store after 2 cycles.
        ld_en = 0;
        st_en = 0;
        ld_q.push_back('{32'h600, 4'b0011});
        st_q.push_back('{32'h700, 32'h77, 4'hF, 1'b1});
        exp_dc.push_back('{32'h600, 32'h0, 4'b0011, 1'b0});
        exp_dc.push_back('{32'h700, 32'h77, 4'hF, 1'b1});
        exp_rd.push_back(32'hCAFE0600);
        ld_en = 1;
        st_en = 1;
        wait_idle(100);
        check("turnaround_gap", last_gap, 2);

        // Reset while in STORE: dropped, then reissued.
        resp_lat = 6;
        st_q.push_back('{32'h800, 32'h88, 4'hF, 1'b1});
        exp_dc.push_back('{32'h800, 32'h88, 4'hF, 1'b1});
        exp_dc.push_back('{32'h800, 32'h88, 4'hF, 1'b1});
        n = 0;
        while (!bus.arb2dcache_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_req_seen", bus.arb2dcache_req, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_req", bus.arb2dcache_req, 0);
        check("midrst_stb_ack", bus.arb2stb_ack, 0);
        check("midrst_starve", dut.starve_cnt, 0);
        check("midrst_state", dut.state, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        resp_lat = 3;
        wait_idle(100);

        check("exp_dc_drained", exp_dc.size(), 0);
        check("exp_rd_drained", exp_rd.size(), 0);
        check("fence_total", fence_seen, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stb_dcache_arbiter.md
Name: stb_dcache_arbiter

Overview:
Shares the single dcache request port between LSU loads and the store buffer drain port. Loads have priority. A starvation counter forces a store grant after STARVE_LIMIT consecutive load wins. A fence handshake blocks loads until the store buffer is fully drained. The block sits between the LSU/MMU, store_buffer_top and the dcache, with one outstanding dcache transaction at a time.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
BYTE_SEL_WIDTH, 4, byte-select width
STARVE_LIMIT, 4, max consecutive load grants while a store is pending (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
lsummu2arb_ld_req  in  1  load request, held until ack
lsummu2arb_ld_addr  in  ADDR_WIDTH  load address
lsummu2arb_ld_sel_byte  in  BYTE_SEL_WIDTH  load byte select
arb2lsummu_ld_ack  out  1  load done, 1-cycle pulse
arb2lsummu_ld_rdata  out  DATA_WIDTH  load data, valid with ld_ack
lsummu2arb_fence_req  in  1  fence request, level, held until fence_done
arb2lsummu_fence_done  out  1  fence complete, 1-cycle pulse
stb2arb_req  in  1  store buffer drain request
stb2arb_addr  in  ADDR_WIDTH  store address
stb2arb_wdata  in  DATA_WIDTH  store data
stb2arb_sel_byte  in  BYTE_SEL_WIDTH  store byte select
stb2arb_w_en  in  1  store write enable
stb2arb_empty  in  1  store buffer empty
arb2stb_ack  out  1  store accepted by dcache, 1-cycle pulse
arb2dcache_addr  out  ADDR_WIDTH  registered address
arb2dcache_wdata  out  DATA_WIDTH  registered write data
arb2dcache_sel_byte  out  BYTE_SEL_WIDTH  registered byte select
arb2dcache_w_en  out  1  registered write enable
arb2dcache_req  out  1  registered request
dcache2arb_ack  in  1  dcache completes current request
dcache2arb_rdata  in  DATA_WIDTH  read data, valid with dcache ack

Behaviour:
- Reset (async, rst=1): state IDLE, starve_cnt=0, all outputs 0.
- FSM states: IDLE, LOAD, STORE.
- IDLE, grant evaluation each cycle:
  - Requests are masked in the cycle the same requester's ack is high (no double grant).
  - store_wins = stb2arb_req && (!ld_req_eff || starve_cnt==STARVE_LIMIT || fence_req).
  - Loads are never granted while fence_req=1.
  - Load grant -> LOAD; store grant -> STORE; no grant -> stay in IDLE.
- Grant edge: addr/sel/wdata/w_en are captured into output registers and arb2dcache_req=1 from the next cycle. Latency from request to dcache req is 1 cycle.
  - Load: w_en=0, wdata=0.
  - Store: inputs are passed through as captured.
- LOAD/STORE: outputs are held stable until dcache2arb_ack=1. On that edge:
  - req=0, w_en=0, state -> IDLE.
  - Next cycle: matching ack pulses for 1 cycle.
  - Load: ld_rdata is captured from dcache2arb_rdata and held until the next load ack.
- Earliest back-to-back: new dcache req appears 2 cycles after the previous dcache ack.
- starve_cnt:
  - +1 on a load grant while stb2arb_req=1, saturating at STARVE_LIMIT.
  - Cleared on any store grant.
  - Cleared when stb2arb_req=0 in IDLE.
- Fence:
  - While fence_req=1, stores keep draining.
  - fence_done pulses for 1 cycle when state=IDLE, stb2arb_empty=1, stb2arb_req=0 and no ack pulse is pending.
  - Not re-pulsed while fence_req stays high after done; it re-arms when fence_req drops.
  - fence_req with an already empty buffer: done 1 cycle later.
- dcache2arb_ack in IDLE is ignored (no ack, no state change).
- Simultaneous ld_req and stb_req with starve_cnt<STARVE_LIMIT and no fence: the load wins.
- Reset mid-transaction: the transaction is dropped, no ack is issued, and the requester reissues.

Test Plan:
- Load only: ld_req addr=0x40 sel=4'b1111, dcache ack 3 cycles after req with rdata=0xDEADBEEF -> dcache req 1 cycle after ld_req with w_en=0; ld_ack 1 cycle after dcache ack with rdata=0xDEADBEEF.
- Store only: stb_req addr=0x100 wdata=0x64 sel=4'b0100 -> dcache addr=0x100 wdata=0x64 w_en=1; stb_ack exactly 1 cycle after dcache ack.
- Starvation with STARVE_LIMIT=4: ld_req and stb_req held continuously -> grant order L,L,L,L,S,L...; starve_cnt returns to 0 after the store grant.
- Fence: 3 entries in store buffer, ld_req pending, fence_req=1 -> 3 store grants, no load grant, fence_done after empty=1; load granted after fence_req drops.
- Simultaneous ld_req and stb_req, starve_cnt=0 -> load granted first; store granted next with no bubble beyond the 2-cycle turnaround.
- Reset asserted while in STORE with req=1 -> req=0 immediately (async), no stb_ack, starve_cnt=0, state IDLE.
